// File: rtl/fft_peak_detect_pkg.sv
// Shared FFT sizing and the {real, imag} bin packing used by the FFT top and its consumers.
// Pure declarations: no latency, no flow control.
package fft_peak_detect_pkg;

    localparam int FFT_W     = 16;
    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;

    function automatic logic [2*FFT_W-1:0] pack_bin(input logic signed [FFT_W-1:0] re,
                                                    input logic signed [FFT_W-1:0] im);
        return {re, im};
    endfunction

    function automatic logic signed [FFT_W-1:0] bin_re(input logic [2*FFT_W-1:0] d);
        return d[2*FFT_W-1:FFT_W];
    endfunction

    function automatic logic signed [FFT_W-1:0] bin_im(input logic [2*FFT_W-1:0] d);
        return d[FFT_W-1:0];
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Squared-magnitude pipeline re^2+im^2 with valid and bin tag carried alongside.
// Three register stages; never stalls, idle beats only shift valid low.
module fft_mag_sq #(
    parameter int W     = 16,
    parameter int LOG2N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic [2*W-1:0]     data,
    input  logic [LOG2N-1:0]   bin,
    output logic               mag_valid,
    output logic [2*W-1:0]     mag,
    output logic [LOG2N-1:0]   mag_bin
);

    logic                    s1_vld;
    logic signed [W-1:0]     s1_re;
    logic signed [W-1:0]     s1_im;
    logic [LOG2N-1:0]        s1_bin;

    logic                    s2_vld;
    logic signed [2*W-1:0]   s2_re2;
    logic signed [2*W-1:0]   s2_im2;
    logic [LOG2N-1:0]        s2_bin;

    // Sign-extend before squaring so the full 2W-bit product is formed.
    logic signed [2*W-1:0]   re_x;
    logic signed [2*W-1:0]   im_x;

    assign re_x = {{W{s1_re[W-1]}}, s1_re};
    assign im_x = {{W{s1_im[W-1]}}, s1_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_bin    <= '0;
            s2_vld    <= 1'b0;
            s2_re2    <= '0;
            s2_im2    <= '0;
            s2_bin    <= '0;
            mag_valid <= 1'b0;
            mag       <= '0;
            mag_bin   <= '0;
        end else begin
            s1_vld    <= valid;
            s2_vld    <= s1_vld;
            mag_valid <= s2_vld;
            if (valid) begin
                s1_re  <= data[2*W-1:W];
                s1_im  <= data[W-1:0];
                s1_bin <= bin;
            end
            if (s1_vld) begin
                s2_re2 <= re_x * re_x;
                s2_im2 <= im_x * im_x;
                s2_bin <= s1_bin;
            end
            // Each square is at most 2^(2W-2), so the sum never exceeds 2^(2W-1).
            if (s2_vld) begin
                mag     <= $unsigned(s2_re2) + $unsigned(s2_im2);
                mag_bin <= s2_bin;
            end
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Streams |X[k]|^2 per FFT bin (3-cycle latency) and reports the strongest bin once per frame.
// No backpressure: accepts a bin on every valid beat; frame pulse comes one cycle after bin N-1's magnitude.
module fft_peak_detect
    import fft_peak_detect_pkg::*;
#(
    parameter int W       = FFT_W,
    parameter int N       = FFT_N,
    parameter int LOG2N   = FFT_LOG2N,
    parameter int SKIP_DC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w_axi_valid,
    input  logic [2*W-1:0]     i_axi,
    input  logic               i_sof,
    output logic               o_mag_valid,
    output logic [2*W-1:0]     o_mag,
    output logic [LOG2N-1:0]   o_mag_bin,
    output logic               o_peak_valid,
    output logic [LOG2N-1:0]   o_peak_bin,
    output logic [2*W-1:0]     o_peak_mag
);

    localparam logic             SKIP      = (SKIP_DC != 0);
    localparam logic [LOG2N-1:0] FIRST_BIN = SKIP ? LOG2N'(1) : LOG2N'(0);
    localparam logic [LOG2N-1:0] LAST_BIN  = LOG2N'(N - 1);

    logic [LOG2N-1:0] bin_cnt;
    logic [LOG2N-1:0] beat_bin;

    logic [2*W-1:0]   run_max;
    logic [LOG2N-1:0] run_idx;
    logic             take;
    logic [2*W-1:0]   nxt_max;
    logic [LOG2N-1:0] nxt_idx;
    logic             frame_end;

    // i_sof resynchronises the count; N is a power of two so wrap is free.
    assign beat_bin = i_sof ? '0 : bin_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt <= '0;
        end else if (w_axi_valid) begin
            bin_cnt <= beat_bin + 1'b1;
        end
    end

    fft_mag_sq #(
        .W     (W),
        .LOG2N (LOG2N)
    ) u_mag_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (w_axi_valid),
        .data      (i_axi),
        .bin       (beat_bin),
        .mag_valid (o_mag_valid),
        .mag       (o_mag),
        .mag_bin   (o_mag_bin)
    );

    // First bin of a frame loads unconditionally, which also discards any partial frame.
    always_comb begin
        take      = 1'b0;
        frame_end = 1'b0;
        if (o_mag_valid && !(SKIP && (o_mag_bin == '0))) begin
            take = (o_mag_bin == FIRST_BIN) || (o_mag > run_max);
        end
        if (o_mag_valid && (o_mag_bin == LAST_BIN)) begin
            frame_end = 1'b1;
        end
        nxt_max = take ? o_mag     : run_max;
        nxt_idx = take ? o_mag_bin : run_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max      <= '0;
            run_idx      <= '0;
            o_peak_valid <= 1'b0;
            o_peak_bin   <= '0;
            o_peak_mag   <= '0;
        end else begin
            o_peak_valid <= frame_end;
            if (o_mag_valid) begin
                run_max <= nxt_max;
                run_idx <= nxt_idx;
            end
            if (frame_end) begin
                o_peak_bin <= nxt_idx;
                o_peak_mag <= nxt_max;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: hand-computed magnitudes, peaks and latencies,
// with a second instance built with SKIP_DC=1 sharing the same stimulus.
module tb_fft_peak_detect;
    import fft_peak_detect_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_axi_valid = 1'b0;
    logic [31:0] i_axi = '0;
    logic        i_sof = 1'b0;

    logic        mag_valid0, pk_valid0, mag_valid1, pk_valid1;
    logic [31:0] mag0, pk_mag0, mag1, pk_mag1;
    logic [2:0]  mag_bin0, pk_bin0, mag_bin1, pk_bin1;

    fft_peak_detect #(.SKIP_DC(0)) u0 (
        .clk(clk), .rst_n(rst_n), .w_axi_valid(w_axi_valid), .i_axi(i_axi), .i_sof(i_sof),
        .o_mag_valid(mag_valid0), .o_mag(mag0), .o_mag_bin(mag_bin0),
        .o_peak_valid(pk_valid0), .o_peak_bin(pk_bin0), .o_peak_mag(pk_mag0)
    );

    fft_peak_detect #(.SKIP_DC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .w_axi_valid(w_axi_valid), .i_axi(i_axi), .i_sof(i_sof),
        .o_mag_valid(mag_valid1), .o_mag(mag1), .o_mag_bin(mag_bin1),
        .o_peak_valid(pk_valid1), .o_peak_bin(pk_bin1), .o_peak_mag(pk_mag1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] mag;
        logic [2:0]  bin;
        int          cyc;
    } rec_t;

    rec_t mq0[$], mq1[$], pq0[$], pq1[$];

    always @(negedge clk) begin
        if (mag_valid0) mq0.push_back('{mag: mag0, bin: mag_bin0, cyc: cyc});
        if (mag_valid1) mq1.push_back('{mag: mag1, bin: mag_bin1, cyc: cyc});
        if (pk_valid0)  pq0.push_back('{mag: pk_mag0, bin: pk_bin0, cyc: cyc});
        if (pk_valid1)  pq1.push_back('{mag: pk_mag1, bin: pk_bin1, cyc: cyc});
    end

    int checks = 0;
    int errors = 0;
    int last_cyc = 0;
    int first_cyc = 0;
    int c_a, c_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic rec_t pick(input rec_t q[$], input int i);
        rec_t r;
        r.mag = 'x;
        r.bin = 'x;
        r.cyc = -1;
        if (i < q.size()) r = q[i];
        return r;
    endfunction

    task automatic clearq();
        mq0.delete(); mq1.delete(); pq0.delete(); pq1.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            w_axi_valid = 1'b0;
            i_sof       = 1'b0;
            i_axi       = '0;
        end
    endtask

    task automatic beat(input int re, input int im, input bit sof);
        logic [15:0] r16, i16;
        r16 = re[15:0];
        i16 = im[15:0];
        @(negedge clk);
        w_axi_valid = 1'b1;
        i_axi       = pack_bin(r16, i16);
        i_sof       = sof;
        last_cyc    = cyc;
    endtask

    task automatic frame(input int re[8], input int im[8], input bit sof0, input int gap);
        for (int k = 0; k < 8; k++) begin
            if (gap > 0) idle(int'($urandom_range(gap, 0)));
            beat(re[k], im[k], sof0 && (k == 0));
            if (k == 0) first_cyc = last_cyc;
        end
    endtask

    initial begin
        int exp_mag[8];
        rec_t r;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mag_valid", mag_valid0, 0);
        chk("rst_mag", mag0, 0);
        chk("rst_mag_bin", mag_bin0, 0);
        chk("rst_peak_valid", pk_valid0, 0);
        chk("rst_peak_bin", pk_bin0, 0);
        chk("rst_peak_mag", pk_mag0, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame
        clearq();
        frame('{0, 100, 0, 3, 0, 0, 0, 0}, '{0, 0, -200, 4, 0, 0, 0, 0}, 1'b0, 0);
        c_a = first_cyc;
        c_b = last_cyc;
        idle(8);
        exp_mag = '{0, 10000, 40000, 25, 0, 0, 0, 0};
        chk("f1_mag_count", mq0.size(), 8);
        for (int i = 0; i < 8; i++) begin
            r = pick(mq0, i);
            chk($sformatf("f1_mag%0d", i), r.mag, exp_mag[i]);
            chk($sformatf("f1_bin%0d", i), r.bin, i);
        end
        chk("f1_mag_latency", pick(mq0, 0).cyc, c_a + 3);
        chk("f1_peak_count", pq0.size(), 1);
        chk("f1_peak_bin", pick(pq0, 0).bin, 2);
        chk("f1_peak_mag", pick(pq0, 0).mag, 40000);
        chk("f1_peak_latency", pick(pq0, 0).cyc, c_b + 4);
        chk("f1_hold_bin", pk_bin0, 2);
        chk("f1_hold_mag", pk_mag0, 40000);
        chk("f1_pulse_once", pk_valid0, 0);

        // Most negative input on both components
        clearq();
        frame('{1, 1, 1, 1, 1, -32768, 1, 1}, '{1, 1, 1, 1, 1, -32768, 1, 1}, 1'b0, 0);
        idle(8);
        chk("ext_mag5", pick(mq0, 5).mag, 32'h8000_0000);
        chk("ext_mag4", pick(mq0, 4).mag, 2);
        chk("ext_peak_bin", pick(pq0, 0).bin, 5);
        chk("ext_peak_mag", pick(pq0, 0).mag, 32'h8000_0000);

        // Tie keeps the lower bin
        clearq();
        frame('{0, 300, 0, 0, 0, 0, 300, 0}, '{0, 400, 0, 0, 0, 0, 400, 0}, 1'b0, 0);
        idle(8);
        chk("tie_peak_bin", pick(pq0, 0).bin, 1);
        chk("tie_peak_mag", pick(pq0, 0).mag, 250000);

        // DC exclusion
        clearq();
        frame('{32767, 0, 0, 10, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0);
        idle(8);
        chk("skip_peak_bin", pick(pq1, 0).bin, 3);
        chk("skip_peak_mag", pick(pq1, 0).mag, 100);
        chk("skip_dc_mag", pick(mq1, 0).mag, 1073676289);
        chk("skip_dc_bin", pick(mq1, 0).bin, 0);
        chk("noskip_peak_bin", pick(pq0, 0).bin, 0);
        chk("noskip_peak_mag", pick(pq0, 0).mag, 1073676289);

        // Back-to-back frames with no gap
        clearq();
        frame('{1, 1, 1, 1, 50, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0);
        c_a = last_cyc;
        frame('{0, 0, 0, 0, 0, 0, 0, -7}, '{0, 0, 0, 0, 0, 0, 0, -7}, 1'b0, 0);
        c_b = last_cyc;
        idle(8);
        chk("b2b_peak_count", pq0.size(), 2);
        chk("b2b_a_bin", pick(pq0, 0).bin, 4);
        chk("b2b_a_mag", pick(pq0, 0).mag, 2500);
        chk("b2b_a_cyc", pick(pq0, 0).cyc, c_a + 4);
        chk("b2b_b_bin", pick(pq0, 1).bin, 7);
        chk("b2b_b_mag", pick(pq0, 1).mag, 98);
        chk("b2b_b_cyc", pick(pq0, 1).cyc, c_b + 4);

        // Frames with random gaps between beats
        clearq();
        frame('{5, 5, -1000, 5, 5, 5, 5, 5}, '{5, 5, 0, 5, 5, 5, 5, 5}, 1'b0, 3);
        frame('{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 3);
        c_b = last_cyc;
        idle(8);
        chk("gap_peak_count", pq0.size(), 2);
        chk("gap_c_bin", pick(pq0, 0).bin, 2);
        chk("gap_c_mag", pick(pq0, 0).mag, 1000000);
        chk("gap_d_bin", pick(pq0, 1).bin, 0);
        chk("gap_d_mag", pick(pq0, 1).mag, 0);
        chk("gap_d_cyc", pick(pq0, 1).cyc, c_b + 4);

        // Start-of-frame in the middle of a frame
        clearq();
        beat(0, 0, 1'b0);
        beat(900, 0, 1'b0);
        beat(0, 0, 1'b0);
        beat(0, 0, 1'b0);
        frame('{6, 0, 0, 0, 0, 0, 0, 0}, '{8, 0, 0, 30, 0, 0, 0, 0}, 1'b1, 0);
        idle(8);
        chk("sof_mag_count", mq0.size(), 12);
        chk("sof_partial_mag", pick(mq0, 1).mag, 810000);
        chk("sof_resync_bin", pick(mq0, 4).bin, 0);
        chk("sof_next_bin", pick(mq0, 5).bin, 1);
        chk("sof_peak_count", pq0.size(), 1);
        chk("sof_peak_bin", pick(pq0, 0).bin, 3);
        chk("sof_peak_mag", pick(pq0, 0).mag, 900);

        // Reset in the middle of a frame
        beat(0, 0, 1'b0);
        beat(900, 0, 1'b0);
        beat(0, 0, 1'b0);
        beat(0, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_mag_valid", mag_valid0, 0);
        chk("mrst_mag", mag0, 0);
        chk("mrst_peak_valid", pk_valid0, 0);
        chk("mrst_peak_bin", pk_bin0, 0);
        chk("mrst_peak_mag", pk_mag0, 0);
        rst_n       = 1'b1;
        w_axi_valid = 1'b0;
        i_axi       = '0;
        clearq();
        idle(1);
        frame('{0, 0, 0, 0, 0, 0, -3, 0}, '{0, 0, 0, 0, 0, 0, -4, 0}, 1'b0, 0);
        idle(8);
        chk("post_mag_count", mq0.size(), 8);
        chk("post_first_bin", pick(mq0, 0).bin, 0);
        chk("post_mag6", pick(mq0, 6).mag, 25);
        chk("post_peak_count", pq0.size(), 1);
        chk("post_peak_bin", pick(pq0, 0).bin, 6);
        chk("post_peak_mag", pick(pq0, 0).mag, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the 8-point FFT top's output stream.
- Takes one complex bin per valid beat, packed as {real, imag}.
- Produces a pipelined squared-magnitude stream, then a once-per-frame report of the strongest bin index and its magnitude.
- Feeds spectrum-monitor and control logic; bins arrive in natural order 0..N-1.

Parameters:
- W, `W (16): signed width of each real/imag component.
- N, 8: bins per frame; power of two.
- LOG2N, 3: bin index width.
- SKIP_DC, 0: when 1, bin 0 is excluded from peak search (still streamed on o_mag).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- w_axi_valid  input  1  i_axi carries a bin this cycle.
- i_axi  input  2*W  {real[2W-1:W], imag[W-1:0]}, two's complement.
- i_sof  input  1  qualified by w_axi_valid; forces this beat to be bin 0.
- o_mag_valid  output  1  o_mag/o_mag_bin valid.
- o_mag  output  2*W  unsigned re^2+im^2.
- o_mag_bin  output  LOG2N  bin index of o_mag.
- o_peak_valid  output  1  one-cycle pulse, frame result valid.
- o_peak_bin  output  LOG2N  index of maximum bin.
- o_peak_mag  output  2*W  magnitude of maximum bin.

Behaviour:
- Reset (async assert, sync-deassert timing assumed on rst_n release):
  - all outputs 0;
  - bin counter 0, running max 0, running index 0;
  - pipeline valids 0.
- Bin counter:
  - increments on each w_axi_valid and wraps N-1 -> 0;
  - w_axi_valid & i_sof loads index 0 for this beat, so the next beat is 1.
- Magnitude pipeline, 3 stages, no stalls, gaps allowed between beats:
  - S1: register re, im, bin, valid.
  - S2: register re*re and im*im. Each is a signed product of 2W bits and non-negative; max (-2^(W-1))^2 = 2^(2W-2).
  - S3: register the sum as 2W-bit unsigned. Max 2^(2W-1) fits, no saturation needed.
- Magnitude latency: o_mag_valid asserts exactly 3 cycles after the accepting w_axi_valid edge.
- Peak tracker, updated on each o_mag_valid-stage result:
  - First bin of a frame (bin 0, or bin 1 when SKIP_DC=1) loads max and index unconditionally.
  - Later bins replace them only if strictly greater, so ties keep the lower bin index.
  - With SKIP_DC=1, bin 0 never updates the tracker.
- Frame completion:
  - When the result for bin N-1 is produced, o_peak_valid pulses the next cycle, 4 cycles after the last input beat.
  - o_peak_bin and o_peak_mag hold their value until the next pulse.
  - The tracker is re-armed in the same cycle, so back-to-back frames with zero gap are supported.
- i_sof mid-frame: the partial frame is discarded with no o_peak_valid. The tracker restarts from the sof beat.
- Reset mid-frame: everything is cleared and the in-flight pipeline is dropped. The first post-reset beat is bin 0.
- w_axi_valid low: no state changes except pipeline valids shifting 0.

Decomposition:
- Shared package/header (alongside width.vh):
  - W;
  - N and LOG2N for the FFT size;
  - the {real, imag} packing field macros, used by the FFT top and this block.
- One natural sub-module: fft_mag_sq, the 3-stage squared-magnitude pipeline (valid + bin tag carried through).
- The peak tracker stays in the top module.

Test Plan:
- Single frame, bins (0,0),(100,0),(0,-200),(3,4), then zeros:
  - o_mag = 0, 10000, 40000, 25, 0...;
  - o_peak_bin = 2, o_peak_mag = 40000, pulse 4 cycles after bin 7.
- Extreme input (-32768,-32768) at bin 5, others small: o_mag = 0x8000_0000, o_peak_bin = 5, no overflow.
- Tie, bins 1 and 6 both (300,400) -> 250000: o_peak_bin = 1.
- SKIP_DC=1, bin 0 = (32767,0), bin 3 = (10,0): o_peak_bin = 3, o_peak_mag = 100; o_mag still reports bin 0 = 1073676289.
- Two frames back-to-back with no gap, then two frames with random gaps: one pulse per frame, correct peaks. Includes i_sof at beat 4 of a frame: the partial frame produces no pulse and the counter resyncs.
- rst_n low for 1 cycle during bin 3, then a clean frame: all outputs 0 during reset, no stale pulse, the following frame reports correctly.
